// File: rtl/updown_pkg.sv
// rtl/updown_pkg.sv - shared types and defaults for the up/down game round controller
package updown_pkg;

    typedef enum logic [1:0] {
        CMP_NONE    = 2'b00,
        CMP_UP      = 2'b01,
        CMP_DOWN    = 2'b10,
        CMP_CORRECT = 2'b11
    } cmp_t;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_GUESS,
        ISSUE,
        EVAL,
        WIN,
        LOSE
    } state_t;

    localparam int          NUM_MAX_DEFAULT      = 99;
    localparam int          MAX_ATTEMPTS_DEFAULT = 7;
    localparam logic [6:0]  LFSR_SEED_DEFAULT    = 7'h5A;

    function automatic logic value_legal(input logic [6:0] v, input logic [6:0] max_v);
        return (v != 7'd0) && (v <= max_v);
    endfunction

endpackage

// File: rtl/updown_lfsr7.sv
// rtl/updown_lfsr7.sv - 7-bit Fibonacci LFSR, x^7+x^6+1, loads seed on reset
module updown_lfsr7 (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] seed,
    output logic [6:0] value
);

    logic [6:0] q;

    // Maximal-length taps: a non-zero seed never reaches the all-zero lock-up state.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= seed;
        end else if (enable) begin
            q <= {q[5:0], q[6] ^ q[5]};
        end
    end

    assign value = q;

endmodule

// File: rtl/updown_game_ctrl.sv
// rtl/updown_game_ctrl.sv - up/down game round controller; optional range tracking via UPDOWN_RANGE_TRACK_EN
module updown_game_ctrl
    import updown_pkg::*;
#(
    parameter int         NUM_MAX      = NUM_MAX_DEFAULT,
    parameter int         MAX_ATTEMPTS = MAX_ATTEMPTS_DEFAULT,
    parameter logic [6:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       guess_trigger,
    input  logic [6:0] user_number,
    input  logic [1:0] comparison_result,
    output logic [6:0] actual_number,
    output logic       dp_guess_trigger,
    output logic       dp_reset,
    output logic [1:0] hint,
    output logic [3:0] attempts,
    output logic       invalid_guess,
    output logic       busy,
    output logic       win,
    output logic       lose,
    output logic [6:0] range_lo,
    output logic [6:0] range_hi
);

    localparam logic [6:0] NMAX = 7'(NUM_MAX);
    localparam logic [3:0] MAXA = 4'(MAX_ATTEMPTS);

    state_t     state, state_next;
    logic [6:0] actual_q, actual_next;
    cmp_t       hint_q, hint_next;
    logic [3:0] att_q, att_next;
    logic       inv_q, inv_next;
    logic       arm_q, arm_next;
    logic [6:0] lfsr_val;
    cmp_t       cmp_in;

`ifdef UPDOWN_RANGE_TRACK_EN
    logic [6:0] guess_q, guess_next;
    logic [6:0] lo_q, lo_next;
    logic [6:0] hi_q, hi_next;
`endif

    updown_lfsr7 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (1'b1),
        .seed   (LFSR_SEED),
        .value  (lfsr_val)
    );

    assign cmp_in = cmp_t'(comparison_result);

    always_comb begin
        state_next  = state;
        actual_next = actual_q;
        hint_next   = hint_q;
        att_next    = att_q;
        inv_next    = 1'b0;
        arm_next    = 1'b0;
`ifdef UPDOWN_RANGE_TRACK_EN
        guess_next  = guess_q;
        lo_next     = lo_q;
        hi_next     = hi_q;
`endif
        case (state)
            IDLE: if (start) state_next = ARM;
            ARM: begin
                if (value_legal(lfsr_val, NMAX)) begin
                    actual_next = lfsr_val;
                    state_next  = WAIT_GUESS;
                end
            end
            WAIT_GUESS: begin
                if (start) begin
                    state_next = ARM;
                end else if (guess_trigger) begin
                    if (value_legal(user_number, NMAX)) begin
`ifdef UPDOWN_RANGE_TRACK_EN
                        guess_next = user_number;
`endif
                        state_next = ISSUE;
                    end else begin
                        inv_next = 1'b1;
                    end
                end
            end
            ISSUE: state_next = start ? ARM : EVAL;
            EVAL: begin
                if (start) begin
                    state_next = ARM;
                end else if (cmp_in == CMP_NONE) begin
                    // Datapath gave no answer: abandon the round without charging an attempt.
                    state_next = IDLE;
                end else begin
                    hint_next = cmp_in;
                    att_next  = att_q + 4'd1;
                    if (cmp_in == CMP_CORRECT) begin
                        state_next = WIN;
                    end else begin
`ifdef UPDOWN_RANGE_TRACK_EN
                        if (guess_q >= lo_q && guess_q <= hi_q) begin
                            if (cmp_in == CMP_UP) lo_next = guess_q + 7'd1;
                            else                  hi_next = guess_q - 7'd1;
                        end
`endif
                        state_next = (att_q + 4'd1 == MAXA) ? LOSE : WAIT_GUESS;
                    end
                end
            end
            WIN, LOSE: if (start) state_next = ARM;
            default: state_next = IDLE;
        endcase

        // Entering ARM from anywhere starts a fresh round.
        if (state_next == ARM && state != ARM) begin
            arm_next  = 1'b1;
            att_next  = 4'd0;
            hint_next = CMP_NONE;
`ifdef UPDOWN_RANGE_TRACK_EN
            lo_next   = 7'd1;
            hi_next   = NMAX;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            actual_q <= 7'd0;
            hint_q   <= CMP_NONE;
            att_q    <= 4'd0;
            inv_q    <= 1'b0;
            arm_q    <= 1'b0;
`ifdef UPDOWN_RANGE_TRACK_EN
            guess_q  <= 7'd0;
            lo_q     <= 7'd1;
            hi_q     <= NMAX;
`endif
        end else begin
            state    <= state_next;
            actual_q <= actual_next;
            hint_q   <= hint_next;
            att_q    <= att_next;
            inv_q    <= inv_next;
            arm_q    <= arm_next;
`ifdef UPDOWN_RANGE_TRACK_EN
            guess_q  <= guess_next;
            lo_q     <= lo_next;
            hi_q     <= hi_next;
`endif
        end
    end

    assign actual_number    = actual_q;
    assign hint             = hint_q;
    assign attempts         = att_q;
    assign invalid_guess    = inv_q;
    assign dp_guess_trigger = (state == ISSUE);
    assign dp_reset         = reset | arm_q;
    assign busy             = (state == ARM) || (state == WAIT_GUESS) ||
                              (state == ISSUE) || (state == EVAL);
    assign win              = (state == WIN);
    assign lose             = (state == LOSE);
`ifdef UPDOWN_RANGE_TRACK_EN
    assign range_lo         = lo_q;
    assign range_hi         = hi_q;
`else
    assign range_lo         = 7'd1;
    assign range_hi         = NMAX;
`endif

endmodule

// File: tb/tb_updown_game_ctrl.sv
// tb/tb_updown_game_ctrl.sv - self-checking bench for updown_game_ctrl with a behavioural datapath and game model
module tb_updown_game_ctrl;

    localparam int NMAX = 99;
    localparam int MAXA = 7;

    logic       clk = 1'b0;
    logic       reset, start, guess_trigger;
    logic [6:0] user_number;
    logic [1:0] comparison_result;
    logic [6:0] actual_number, range_lo, range_hi;
    logic       dp_guess_trigger, dp_reset, invalid_guess, busy, win, lose;
    logic [1:0] dut_hint;
    logic [3:0] attempts;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    updown_game_ctrl #(.NUM_MAX(NMAX), .MAX_ATTEMPTS(MAXA), .LFSR_SEED(7'h5A)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .guess_trigger     (guess_trigger),
        .user_number       (user_number),
        .comparison_result (comparison_result),
        .actual_number     (actual_number),
        .dp_guess_trigger  (dp_guess_trigger),
        .dp_reset          (dp_reset),
        .hint              (dut_hint),
        .attempts          (attempts),
        .invalid_guess     (invalid_guess),
        .busy              (busy),
        .win               (win),
        .lose              (lose),
        .range_lo          (range_lo),
        .range_hi          (range_hi)
    );

    // Datapath stand-in: latches the guess on the strobe, compares combinationally.
    logic [6:0] dp_guess;
    logic       dp_valid;
    logic       force_en, fault;
    logic [6:0] force_val;
    logic [6:0] tgt;
    int         strobes = 0;
    int         dpr_pulses = 0;

    always @(posedge clk) begin
        if (dp_reset) dp_valid <= 1'b0;
        else if (dp_guess_trigger) begin
            dp_guess <= user_number;
            dp_valid <= 1'b1;
        end
        if (dp_guess_trigger) strobes++;
        if (dp_reset && !reset) dpr_pulses++;
    end

    assign tgt = force_en ? force_val : actual_number;

    always_comb begin
        comparison_result = 2'b00;
        if (dp_valid && !fault) begin
            if (dp_guess < tgt)      comparison_result = 2'b01;
            else if (dp_guess > tgt) comparison_result = 2'b10;
            else                     comparison_result = 2'b11;
        end
    end

    // Game-level reference model
    int m_att, m_hint, m_lo, m_hi, m_tgt;
    bit m_win, m_lose;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_new_round(input int target);
        m_att = 0; m_hint = 0; m_lo = 1; m_hi = NMAX;
        m_win = 0; m_lose = 0; m_tgt = target;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start a round with a bench-chosen target and wait out the ARM search.
    task automatic forced_round(input int target);
        force_en  = 1'b1;
        force_val = 7'(target);
        pulse_start();
        repeat (130) @(negedge clk);
        model_new_round(target);
    endtask

    task automatic do_guess(input int g);
        int  s0;
        bit  active, legal;
        s0     = strobes;
        active = !(m_win || m_lose);
        legal  = (g >= 1) && (g <= NMAX);
        user_number   = 7'(g);
        guess_trigger = 1'b1;
        @(negedge clk);
        guess_trigger = 1'b0;
        chk("invalid_pulse", invalid_guess, int'(active && !legal));
        chk("strobe_issue", dp_guess_trigger, int'(active && legal));
        @(negedge clk);
        chk("attempts_before_latency", attempts, m_att);
        @(negedge clk);
        if (active && legal) begin
            m_att++;
            if (g == m_tgt) begin
                m_hint = 3; m_win = 1;
            end else begin
                m_hint = (g < m_tgt) ? 1 : 2;
`ifdef UPDOWN_RANGE_TRACK_EN
                if (g >= m_lo && g <= m_hi) begin
                    if (g < m_tgt) m_lo = g + 1;
                    else           m_hi = g - 1;
                end
`endif
                if (m_att == MAXA) m_lose = 1;
            end
        end
        chk("hint_value", dut_hint, m_hint);
        chk("attempts", attempts, m_att);
        chk("win", win, m_win);
        chk("lose", lose, m_lose);
        chk("range_lo", range_lo, m_lo);
        chk("range_hi", range_hi, m_hi);
        chk("strobe_count", strobes - s0, int'(active && legal));
    endtask

    task automatic check_reset_values();
        chk("rst_busy", busy, 0);
        chk("rst_win", win, 0);
        chk("rst_lose", lose, 0);
        chk("rst_attempts", attempts, 0);
        chk("rst_hint", dut_hint, 0);
        chk("rst_actual", actual_number, 0);
        chk("rst_invalid", invalid_guess, 0);
        chk("rst_strobe", dp_guess_trigger, 0);
        chk("rst_range_lo", range_lo, 1);
        chk("rst_range_hi", range_hi, NMAX);
    endtask

    typedef struct {
        int guess;
        int hint;
        int att;
        bit win;
        bit inv;
        int lo;
        int hi;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int ok, s0, a0;
        reset = 1'b1; start = 1'b0; guess_trigger = 1'b0; user_number = 7'd0;
        force_en = 1'b0; fault = 1'b0; force_val = 7'd0;

`ifdef UPDOWN_RANGE_TRACK_EN
        tbl[0] = '{50, 2, 1, 0, 0, 1, 49};
        tbl[1] = '{0, 2, 1, 0, 1, 1, 49};
        tbl[2] = '{30, 1, 2, 0, 0, 31, 49};
        tbl[3] = '{100, 1, 2, 0, 1, 31, 49};
        tbl[4] = '{42, 3, 3, 1, 0, 31, 49};
        tbl[5] = '{42, 3, 3, 1, 0, 31, 49};
`else
        tbl[0] = '{50, 2, 1, 0, 0, 1, 99};
        tbl[1] = '{0, 2, 1, 0, 1, 1, 99};
        tbl[2] = '{30, 1, 2, 0, 0, 1, 99};
        tbl[3] = '{100, 1, 2, 0, 1, 1, 99};
        tbl[4] = '{42, 3, 3, 1, 0, 1, 99};
        tbl[5] = '{42, 3, 3, 1, 0, 1, 99};
`endif

        repeat (3) @(negedge clk);
        chk("dp_reset_in_reset", dp_reset, 1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();

        // First round uses the LFSR target.
        pulse_start();
        ok = 0;
        for (int i = 0; i < 130; i++) begin
            if (actual_number != 7'd0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("arm_exit_bounded", ok, 1);
        chk("target_in_range", int'(actual_number >= 1 && actual_number <= NMAX), 1);
        chk("busy_after_arm", busy, 1);
        chk("attempts_after_arm", attempts, 0);
        chk("dp_reset_pulses", dpr_pulses, 1);

        // Invalid guesses on a fresh round.
        forced_round(42);
        do_guess(0);
        do_guess(100);
        chk("invalid_attempts", attempts, 0);

        // Table: target 42, DOWN / UP / CORRECT interleaved with rejects, then a post-win guess.
        forced_round(42);
        for (int i = 0; i < 6; i++) begin
            s0 = strobes;
            do_guess(tbl[i].guess);
            chk("tbl_hint", dut_hint, tbl[i].hint);
            chk("tbl_attempts", attempts, tbl[i].att);
            chk("tbl_win", win, tbl[i].win);
            chk("tbl_range_lo", range_lo, tbl[i].lo);
            chk("tbl_range_hi", range_hi, tbl[i].hi);
            chk("tbl_strobe", strobes - s0, int'(!tbl[i].inv && i != 5 && tbl[i].guess != 0));
        end

        // Seven misses lose; an eighth guess is ignored.
        forced_round(42);
        for (int g = 1; g <= 7; g++) do_guess(g);
        chk("lose_level", lose, 1);
        chk("lose_attempts", attempts, 7);
        s0 = strobes;
        do_guess(8);
        chk("lose_no_strobe", strobes - s0, 0);
        chk("lose_attempts_held", attempts, 7);

        // start beats a simultaneous guess_trigger after two attempts.
        forced_round(60);
        do_guess(10);
        do_guess(90);
        s0 = strobes;
        user_number = 7'd50; start = 1'b1; guess_trigger = 1'b1;
        @(negedge clk);
        start = 1'b0; guess_trigger = 1'b0;
        chk("abort_attempts", attempts, 0);
        chk("abort_hint", dut_hint, 0);
        chk("abort_busy", busy, 1);
        chk("abort_invalid", invalid_guess, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_strobe", strobes - s0, 0);
        repeat (130) @(negedge clk);

        // Datapath reports nothing in EVAL: round dropped, nothing counted.
        forced_round(33);
        fault = 1'b1;
        user_number = 7'd20; guess_trigger = 1'b1;
        @(negedge clk);
        guess_trigger = 1'b0;
        repeat (2) @(negedge clk);
        chk("fault_busy", busy, 0);
        chk("fault_attempts", attempts, 0);
        chk("fault_hint", dut_hint, 0);
        fault = 1'b0;

        // Reset asserted while in EVAL.
        forced_round(77);
        user_number = 7'd10; guess_trigger = 1'b1;
        @(negedge clk);
        guess_trigger = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("dp_reset_mid_round", dp_reset, 1);
        reset = 1'b0;
        check_reset_values();
        s0 = strobes;
        user_number = 7'd10; guess_trigger = 1'b1;
        @(negedge clk);
        guess_trigger = 1'b0;
        chk("idle_ignore_invalid", invalid_guess, 0);
        repeat (2) @(negedge clk);
        chk("idle_ignore_strobe", strobes - s0, 0);
        chk("idle_ignore_attempts", attempts, 0);
        chk("idle_ignore_busy", busy, 0);

        // Randomized rounds against the model.
        for (int r = 0; r < 8; r++) begin
            forced_round($urandom_range(1, NMAX));
            for (int k = 0; k < 12; k++) begin
                a0 = $urandom_range(0, 9);
                if (a0 == 0)      do_guess(0);
                else if (a0 == 1) do_guess($urandom_range(NMAX + 1, 127));
                else if (a0 == 2) do_guess(m_tgt);
                else              do_guess($urandom_range(m_lo, m_hi));
                if ((m_win || m_lose) && $urandom_range(0, 1) == 1) break;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/updown_game_ctrl.md
Name: updown_game_ctrl

Overview:
- Round controller for the up/down number-guessing game.
- Picks a secret target from a free-running LFSR and drives it to the guess/compare datapath as actual_number.
- Forwards validated guess strobes to the datapath, reads back comparison_result, counts attempts and declares WIN or LOSE.
- Sits between the debounced button/switch front end and the guess/compare datapath; its status outputs feed the display logic.

Parameters:
- NUM_MAX, 99, largest legal target/guess value; 1..127.
- MAX_ATTEMPTS, 7, guesses allowed per round; 1..15.
- LFSR_SEED, 7'h5A, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new round
- guess_trigger  in  1  one-cycle pulse; user submits user_number
- user_number  in  7  current switch value
- comparison_result  in  2  from datapath: 00 none, 01 UP (guess<target), 10 DOWN (guess>target), 11 CORRECT
- actual_number  out  7  secret target driven to datapath
- dp_guess_trigger  out  1  one-cycle strobe forwarded to datapath
- dp_reset  out  1  datapath reset (reset OR round start)
- hint  out  2  last registered comparison, same encoding
- attempts  out  4  guesses consumed this round
- invalid_guess  out  1  one-cycle pulse on rejected guess
- busy  out  1  high in ARM/WAIT_GUESS/ISSUE/EVAL
- win  out  1  level, high in WIN
- lose  out  1  level, high in LOSE
- range_lo  out  7  lowest still-possible value
- range_hi  out  7  highest still-possible value

Behaviour:
- Clock and reset: single clock domain. reset is synchronous and active-high.
- Reset values: state IDLE, LFSR=LFSR_SEED, actual_number=0, hint=00, attempts=0, dp_guess_trigger=0, invalid_guess=0, win=0, lose=0, busy=0, range_lo=1, range_hi=NUM_MAX. dp_reset=1 during reset.
- LFSR: 7-bit Fibonacci, x^7+x^6+1. Steps every cycle, never zero.
- IDLE: start -> ARM. In ARM, attempts, hint and range are cleared, and dp_reset is pulsed for one cycle.
- ARM: if the LFSR value is in 1..NUM_MAX, latch it into actual_number -> WAIT_GUESS. Otherwise stay in ARM and re-sample next cycle. Exit is bounded by at most 127 cycles.
- WAIT_GUESS, on guess_trigger:
  - If user_number is 0 or greater than NUM_MAX: pulse invalid_guess for one cycle, attempts unchanged, stay in WAIT_GUESS.
  - Otherwise -> ISSUE.
- ISSUE: drive dp_guess_trigger=1 for exactly one cycle -> EVAL.
- EVAL (datapath latches the guess at the ISSUE edge; compare is combinational):
  - Sample comparison_result into hint and increment attempts.
  - 11 -> WIN.
  - Otherwise, if attempts+1 == MAX_ATTEMPTS -> LOSE.
  - Otherwise -> WAIT_GUESS.
  - A result of 00 in EVAL is treated as a fault: -> IDLE, nothing counted.
- Latency: guess_trigger to updated hint/attempts is 3 cycles.
- WIN/LOSE: outputs held; actual_number stays visible. start -> ARM (new round). guess_trigger is ignored.
- guess_trigger in IDLE, ARM, ISSUE or EVAL is ignored (no queuing).
- start in WAIT_GUESS, ISSUE or EVAL aborts the round -> ARM. start has priority over a simultaneous guess_trigger.
- reset mid-round overrides everything on the next edge.
- attempts never exceeds MAX_ATTEMPTS; arithmetic is 4-bit unsigned with no wrap.

Optional Feature:
- Macro: UPDOWN_RANGE_TRACK_EN.
- Defined: in EVAL, UP sets range_lo=guess+1 and DOWN sets range_hi=guess-1, using the guess captured in WAIT_GUESS. A guess outside [range_lo, range_hi] is still legal and counts as an attempt, but does not widen the range.
- Undefined: range_lo is constant 1 and range_hi is constant NUM_MAX; no capture register exists.

Decomposition:
- Package updown_pkg holds:
  - the cmp_t encoding (CMP_NONE, CMP_UP, CMP_DOWN, CMP_CORRECT);
  - the state enum (IDLE, ARM, WAIT_GUESS, ISSUE, EVAL, WIN, LOSE);
  - default NUM_MAX and MAX_ATTEMPTS.
- One sub-module, updown_lfsr7: enable, seed, 7-bit output.
- The FSM stays in this block.

Test Plan:
- Reset, then start, with a stubbed datapath -> ARM exits within 127 cycles. actual_number is in 1..99, busy=1, attempts=0, dp_reset pulsed once.
- Target forced to 42 via the bench datapath model; guesses 50, 30, 42 -> hints DOWN, UP, CORRECT, each 3 cycles after its trigger. win=1 and attempts=3. With UPDOWN_RANGE_TRACK_EN: after 30, range 31..49.
- MAX_ATTEMPTS=7; seven wrong guesses -> lose=1, attempts=7. An eighth guess_trigger has no effect and dp_guess_trigger stays 0.
- Guesses 0 and 100 -> invalid_guess pulses, attempts=0, no dp_guess_trigger.
- start and guess_trigger asserted in the same cycle during WAIT_GUESS after 2 attempts -> new round, attempts=0, hint=00, no strobe issued.
- reset asserted in EVAL -> next edge: IDLE with all outputs at their reset values. A subsequent guess_trigger is ignored.
